// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one 8-bit SPI master core among NUM_REQ requesters,
// with a RUN watchdog and a guard gap that keeps the core stopped between transfers.
module spi_txn_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned GAP_CYCLES     = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NUM_REQ-1:0]     REQ,
  input  logic [8*NUM_REQ-1:0]   REQ_DATA,
  output logic [NUM_REQ-1:0]     ACK,
  output logic [7:0]             RSP_DATA,
  output logic                   RSP_ERR,
  output logic                   RSP_VALID,
  output logic                   BUSY,
  output logic [7:0]             MST_DATA_OUT,
  output logic                   MST_START_N,
  input  logic                   MST_END,
  input  logic [7:0]             MST_DATA_IN
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE,
    ST_GAP
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [7:0]         tx_q, tx_d;
  logic [WD_W-1:0]    wdog_q, wdog_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               start_n_q, start_n_d;
  logic [7:0]         rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               busy_q, busy_d;

  logic               pick_ok_c;
  logic [IDX_W-1:0]   pick_idx_c;

  // First asserted request after the pointer, wrapping modulo NUM_REQ.
  always_comb begin : rr_pick
    logic [IDX_W-1:0] cand;
    pick_ok_c  = 1'b0;
    pick_idx_c = '0;
    cand       = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(ptr_q) + k) % NUM_REQ);
      if (!pick_ok_c && REQ[cand]) begin
        pick_ok_c  = 1'b1;
        pick_idx_c = cand;
      end
    end
  end

  always_comb begin : fsm_next
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    tx_d       = tx_q;
    wdog_d     = wdog_q;
    gap_d      = gap_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_ok_c) begin
          win_d   = pick_idx_c;
          tx_d    = REQ_DATA[{pick_idx_c, 3'b000} +: 8];
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        wdog_d = '0;
        // A stale end flag from the previous byte must clear before the core is started.
        if (!MST_END) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (MST_END) begin
          rsp_data_d = MST_DATA_IN;
          rsp_err_d  = 1'b0;
          state_d    = ST_DONE;
        end else if (wdog_q == WD_LAST) begin
          rsp_data_d = 8'h00;
          rsp_err_d  = 1'b1;
          state_d    = ST_DONE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      ST_DONE: begin
        ptr_d   = win_q;
        gap_d   = '0;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          if (!MST_END) state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered and decoded from the state being entered.
    start_n_d   = (state_d != ST_RUN);
    busy_d      = (state_d != ST_IDLE);
    rsp_valid_d = (state_d == ST_DONE);
    ack_d       = '0;
    if (state_d == ST_DONE) ack_d[win_d] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      ptr_q       <= IDX_W'(NUM_REQ - 1);
      win_q       <= '0;
      tx_q        <= '0;
      wdog_q      <= '0;
      gap_q       <= '0;
      start_n_q   <= 1'b1;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      ack_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      tx_q        <= tx_d;
      wdog_q      <= wdog_d;
      gap_q       <= gap_d;
      start_n_q   <= start_n_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
    end
  end

  assign ACK          = ack_q;
  assign RSP_DATA     = rsp_data_q;
  assign RSP_ERR      = rsp_err_q;
  assign RSP_VALID    = rsp_valid_q;
  assign BUSY         = busy_q;
  assign MST_DATA_OUT = tx_q;
  assign MST_START_N  = start_n_q;

endmodule
